wb_responder: RTL and testbench

Behavioural back-end responder for the front-end pipeline. It consumes the two renamed-instruction lanes leaving the rename stage and queues them in order with a sequentially assigned active-list index. After a fixed execute latency it drives the four writeback ports back into rename, which closes the loop so fetch/decode/rename can be exercised on-chip without real execution units. It also back-pressures rename through a stall output when its queue cannot take a full dual-issue group.

---
 rtl/wb_responder.sv | 136 +++++++++++++
 tb/tb_wb_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_responder.sv
// wb_responder: in-order latency queue that turns renamed instructions into
// writebacks after a fixed delay, with stall back-pressure toward rename.
module wb_responder #(
  parameter int DEPTH    = 8,
  parameter int LATENCY  = 3,
  parameter int WB_PORTS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ext_flush,
  input  logic [1:0]               i_valid,
  input  logic [1:0]               i_uses_rd,
  input  logic [1:0][5:0]          i_rd,
  output logic                     o_stall,
  output logic [WB_PORTS-1:0]      o_wb_valid,
  output logic [WB_PORTS-1:0][3:0] o_wb_al_idx,
  output logic [WB_PORTS-1:0][5:0] o_wb_rd,
  output logic [WB_PORTS-1:0]      o_wb_uses_rd
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CTW = PW + 1;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_INIT    = CW'(LATENCY - 1);
  localparam logic [CTW-1:0] STALL_LEVEL = CTW'(DEPTH - 2);

  logic [3:0]    al_mem_r   [DEPTH];
  logic [5:0]    rd_mem_r   [DEPTH];
  logic          uses_mem_r [DEPTH];
  logic [CW-1:0] cnt_mem_r  [DEPTH];

  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [CTW-1:0] count_r;
  logic [3:0]     al_next_r;

  logic           accept_s;
  logic           acc0_s;
  logic           acc1_s;
  logic [1:0]     n_acc_s;
  logic [PW-1:0]  lane1_slot_s;
  logic [2:0]     n_ret_s;
  logic           scan_stop_s;
  logic [PW-1:0]  scan_idx_s;

  // Stall looks only at registered occupancy, never at this cycle's retirements.
  assign o_stall = (count_r > STALL_LEVEL);

  // Lane acceptance: lane 0 takes the tail slot, lane 1 the one after it.
  always_comb begin
    accept_s     = ~o_stall & ~ext_flush;
    acc0_s       = accept_s & i_valid[0];
    acc1_s       = accept_s & i_valid[1];
    n_acc_s      = {1'b0, acc0_s} + {1'b0, acc1_s};
    lane1_slot_s = tail_r + PW'(acc0_s);
  end

  // Retire scan: count ready entries from head, stopping at the first busy one.
  always_comb begin
    n_ret_s     = 3'd0;
    scan_stop_s = 1'b0;
    scan_idx_s  = head_r;
    for (int i = 0; i < WB_PORTS; i++) begin
      scan_idx_s = head_r + PW'(i);
      if (!scan_stop_s && (CTW'(i) < count_r) && (cnt_mem_r[scan_idx_s] == CW'(0))) begin
        n_ret_s = n_ret_s + 3'd1;
      end else begin
        scan_stop_s = 1'b1;
      end
    end
  end

  // Queue storage, pointers, index counter and registered writeback ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      al_next_r <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        al_mem_r[i]   <= 4'd0;
        rd_mem_r[i]   <= 6'd0;
        uses_mem_r[i] <= 1'b0;
        cnt_mem_r[i]  <= '0;
      end
      o_wb_valid   <= '0;
      o_wb_al_idx  <= '0;
      o_wb_rd      <= '0;
      o_wb_uses_rd <= '0;
    end else if (ext_flush) begin
      head_r       <= '0;
      tail_r       <= '0;
      count_r      <= '0;
      o_wb_valid   <= '0;
      o_wb_al_idx  <= '0;
      o_wb_rd      <= '0;
      o_wb_uses_rd <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_mem_r[i] != CW'(0)) begin
          cnt_mem_r[i] <= cnt_mem_r[i] - CW'(1);
        end
      end
      if (acc0_s) begin
        al_mem_r[tail_r]   <= al_next_r;
        rd_mem_r[tail_r]   <= i_rd[0];
        uses_mem_r[tail_r] <= i_uses_rd[0];
        cnt_mem_r[tail_r]  <= CNT_INIT;
      end
      if (acc1_s) begin
        al_mem_r[lane1_slot_s]   <= al_next_r + 4'(acc0_s);
        rd_mem_r[lane1_slot_s]   <= i_rd[1];
        uses_mem_r[lane1_slot_s] <= i_uses_rd[1];
        cnt_mem_r[lane1_slot_s]  <= CNT_INIT;
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (3'(p) < n_ret_s) begin
          o_wb_valid[p]   <= 1'b1;
          o_wb_al_idx[p]  <= al_mem_r[head_r + PW'(p)];
          o_wb_rd[p]      <= rd_mem_r[head_r + PW'(p)];
          o_wb_uses_rd[p] <= uses_mem_r[head_r + PW'(p)];
        end else begin
          o_wb_valid[p]   <= 1'b0;
          o_wb_al_idx[p]  <= 4'd0;
          o_wb_rd[p]      <= 6'd0;
          o_wb_uses_rd[p] <= 1'b0;
        end
      end
      head_r    <= head_r + PW'(n_ret_s);
      tail_r    <= tail_r + PW'(n_acc_s);
      count_r   <= count_r + CTW'(n_acc_s) - CTW'(n_ret_s);
      al_next_r <= al_next_r + 4'(n_acc_s);
    end
  end

endmodule

// File: tb/tb_wb_responder.sv
// tb_wb_responder: three responders (LATENCY 3, 8, 1) on shared inputs, each
// checked every cycle against a timestamp-based queue model.
module tb_wb_responder;

  localparam int DEPTH = 8;
  localparam int NU    = 3;
  localparam int MQ    = 64;

  logic            clk;
  logic            reset;
  logic            ext_flush;
  logic [1:0]      i_valid;
  logic [1:0]      i_uses_rd;
  logic [1:0][5:0] i_rd;

  logic            stall    [NU];
  logic [3:0]      wb_valid [NU];
  logic [3:0][3:0] wb_al    [NU];
  logic [3:0][5:0] wb_rd    [NU];
  logic [3:0]      wb_uses  [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    wb_responder #(
      .DEPTH(DEPTH),
      .LATENCY((g == 0) ? 3 : ((g == 1) ? 8 : 1)),
      .WB_PORTS(4)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .ext_flush(ext_flush),
      .i_valid(i_valid),
      .i_uses_rd(i_uses_rd),
      .i_rd(i_rd),
      .o_stall(stall[g]),
      .o_wb_valid(wb_valid[g]),
      .o_wb_al_idx(wb_al[g]),
      .o_wb_rd(wb_rd[g]),
      .o_wb_uses_rd(wb_uses[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int edge_no;

  // Model: each entry remembers the edge it was accepted on.
  int m_al   [NU][MQ];
  int m_rd   [NU][MQ];
  int m_uses [NU][MQ];
  int m_t    [NU][MQ];
  int m_head [NU];
  int m_occ  [NU];
  int m_next [NU];

  logic [3:0]  e_valid [NU];
  logic [15:0] e_al    [NU];
  logic [23:0] e_rd    [NU];
  logic [3:0]  e_uses  [NU];

  function automatic int lat_of(input int u);
    case (u)
      0:       return 3;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input int u, input int rd, input int uses);
    int s;
    s = (m_head[u] + m_occ[u]) % MQ;
    m_al[u][s]   = m_next[u];
    m_rd[u][s]   = rd;
    m_uses[u][s] = uses;
    m_t[u][s]    = edge_no;
    m_occ[u]++;
    m_next[u] = (m_next[u] + 1) % 16;
  endtask

  task automatic model_edge();
    bit stl;
    int n;
    int s;
    edge_no++;
    for (int u = 0; u < NU; u++) begin
      e_valid[u] = '0;
      e_al[u]    = '0;
      e_rd[u]    = '0;
      e_uses[u]  = '0;
      if (reset) begin
        m_head[u] = 0;
        m_occ[u]  = 0;
        m_next[u] = 0;
      end else if (ext_flush) begin
        m_occ[u] = 0;
      end else begin
        stl = (m_occ[u] > DEPTH - 2);
        n = 0;
        s = m_head[u];
        while (n < 4 && n < m_occ[u] && (m_t[u][s] + lat_of(u) <= edge_no)) begin
          e_valid[u][n]       = 1'b1;
          e_al[u][n*4 +: 4]   = 4'(m_al[u][s]);
          e_rd[u][n*6 +: 6]   = 6'(m_rd[u][s]);
          e_uses[u][n]        = 1'(m_uses[u][s]);
          n++;
          s = (m_head[u] + n) % MQ;
        end
        m_head[u] = (m_head[u] + n) % MQ;
        m_occ[u]  = m_occ[u] - n;
        if (!stl) begin
          if (i_valid[0]) model_push(u, int'(i_rd[0]), int'(i_uses_rd[0]));
          if (i_valid[1]) model_push(u, int'(i_rd[1]), int'(i_uses_rd[1]));
        end
      end
    end
  endtask

  task automatic check_all();
    for (int u = 0; u < NU; u++) begin
      check_value($sformatf("u%0d_stall", u), 32'(stall[u]), 32'(m_occ[u] > DEPTH - 2));
      check_value($sformatf("u%0d_valid", u), 32'(wb_valid[u]), 32'(e_valid[u]));
      check_value($sformatf("u%0d_al", u), 32'(wb_al[u]), 32'(e_al[u]));
      check_value($sformatf("u%0d_rd", u), 32'(wb_rd[u]), 32'(e_rd[u]));
      check_value($sformatf("u%0d_uses", u), 32'(wb_uses[u]), 32'(e_uses[u]));
    end
  endtask

  task automatic drive_cycle(input logic rst, input logic fl, input logic [1:0] v,
                             input logic [1:0] us, input logic [5:0] rd0, input logic [5:0] rd1);
    reset     = rst;
    ext_flush = fl;
    i_valid   = v;
    i_uses_rd = us;
    i_rd[0]   = rd0;
    i_rd[1]   = rd1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    edge_no   = 0;
    reset     = 1'b1;
    ext_flush = 1'b0;
    i_valid   = 2'b00;
    i_uses_rd = 2'b00;
    i_rd      = '0;
    for (int u = 0; u < NU; u++) begin
      m_head[u] = 0;
      m_occ[u]  = 0;
      m_next[u] = 0;
    end
    @(negedge clk);

    // Reset state.
    drive_cycle(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
    drive_cycle(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
    check_value("rst_valid", 32'(wb_valid[0]), 32'd0);
    check_value("rst_stall", 32'(stall[0]), 32'd0);

    // Single instruction, LATENCY 3.
    drive_cycle(1'b0, 1'b0, 2'b01, 2'b01, 6'd5, 6'd0);
    idle(3);
    check_value("single_valid", 32'(wb_valid[0]), 32'h1);
    check_value("single_al", 32'(wb_al[0][0]), 32'd0);
    check_value("single_rd", 32'(wb_rd[0][0]), 32'd5);
    check_value("single_uses", 32'(wb_uses[0]), 32'h1);
    idle(1);
    check_value("single_idle", 32'(wb_valid[0]), 32'h0);

    // Dual issue then lone lane 1.
    drive_cycle(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, 6'd7, 6'd9);
    drive_cycle(1'b0, 1'b0, 2'b10, 2'b10, 6'd0, 6'd3);
    idle(2);
    check_value("dual_valid", 32'(wb_valid[0]), 32'h3);
    check_value("dual_al1", 32'(wb_al[0][1]), 32'd1);
    check_value("dual_rd1", 32'(wb_rd[0][1]), 32'd9);
    idle(1);
    check_value("lone_al", 32'(wb_al[0][0]), 32'd2);
    check_value("lone_rd", 32'(wb_rd[0][0]), 32'd3);

    // Backpressure: both lanes every cycle.
    drive_cycle(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, 6'(2*k), 6'(2*k+1));
    check_value("bp_nostall", 32'(stall[1]), 32'd0);
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, 6'd6, 6'd7);
    check_value("bp_stall", 32'(stall[1]), 32'd1);
    for (int k = 0; k < 20; k++) drive_cycle(1'b0, 1'b0, 2'b11, 2'b01, 6'(k+10), 6'(k+40));
    idle(12);

    // Flush with four pending, inputs in flush cycle dropped.
    drive_cycle(1'b1, 1'b0, 2'b00, 2'b00, 6'd0, 6'd0);
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, 6'd1, 6'd2);
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, 6'd3, 6'd4);
    drive_cycle(1'b0, 1'b1, 2'b11, 2'b11, 6'd5, 6'd6);
    idle(9);
    check_value("flush_quiet", 32'(wb_valid[1]), 32'd0);
    drive_cycle(1'b0, 1'b0, 2'b01, 2'b01, 6'd33, 6'd0);
    idle(1);
    check_value("flush_al", 32'(wb_al[2][0]), 32'd4);

    // Same sequence with reset instead of flush.
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, 6'd1, 6'd2);
    drive_cycle(1'b0, 1'b0, 2'b11, 2'b11, 6'd3, 6'd4);
    drive_cycle(1'b1, 1'b0, 2'b11, 2'b11, 6'd5, 6'd6);
    check_value("reset_quiet", 32'(wb_valid[0]), 32'd0);
    idle(9);
    drive_cycle(1'b0, 1'b0, 2'b01, 2'b01, 6'd44, 6'd0);
    idle(1);
    check_value("reset_al", 32'(wb_al[2][0]), 32'd0);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 600; k++) begin
      drive_cycle(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 59) == 0),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
